// File: rtl/axi_lite_mem_ctrl.sv
// AXI4-Lite slave serving an internal byte-writable RAM (region 1) and a read-only
// external ROM (region 0); independent read and write FSMs with a saturating error counter.
module axi_lite_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 10,
    parameter int ROM_AW = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  mem_axi_awvalid,
    output logic                  mem_axi_awready,
    input  logic [ADDR_W-1:0]     mem_axi_awaddr,
    input  logic [2:0]            mem_axi_awprot,
    input  logic                  mem_axi_wvalid,
    output logic                  mem_axi_wready,
    input  logic [DATA_W-1:0]     mem_axi_wdata,
    input  logic [DATA_W/8-1:0]   mem_axi_wstrb,
    output logic                  mem_axi_bvalid,
    input  logic                  mem_axi_bready,
    output logic [1:0]            mem_axi_bresp,
    input  logic                  mem_axi_arvalid,
    output logic                  mem_axi_arready,
    input  logic [ADDR_W-1:0]     mem_axi_araddr,
    input  logic [2:0]            mem_axi_arprot,
    output logic                  mem_axi_rvalid,
    input  logic                  mem_axi_rready,
    output logic [DATA_W-1:0]     mem_axi_rdata,
    output logic [1:0]            mem_axi_rresp,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    input  logic                  rom_valid,
    output logic [7:0]            err_count
);
    localparam int STRB_W    = DATA_W / 8;
    localparam int LSB       = $clog2(STRB_W);
    localparam int RAM_DEPTH = 1 << RAM_AW;
    localparam logic [3:0] REG_ROM = 4'd0;
    localparam logic [3:0] REG_RAM = 4'd1;
    localparam logic [DATA_W-1:0] UNMAPPED_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;

    r_state_e            r_state_q, r_state_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [3:0]          ar_region_q, ar_region_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;

    w_state_e            w_state_q, w_state_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [3:0]          aw_region_q, aw_region_d;
    logic [RAM_AW-1:0]   aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [7:0]          err_q, err_d;

    logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                ram_we, ram_re;
    logic [RAM_AW-1:0]   ar_ram_idx;
    logic [DATA_W-1:0]   ram_rd;
    logic [3:0]          ar_region_in;
    logic [1:0]          err_inc;
    logic [8:0]          err_sum;
    logic                unused_bits;

    assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_awaddr, mem_axi_araddr};

    assign ar_hs = (r_state_q == R_IDLE) && arready_q && mem_axi_arvalid;
    assign r_hs  = rvalid_q && mem_axi_rready;
    assign aw_hs = (w_state_q == W_IDLE) && awready_q && mem_axi_awvalid;
    assign w_hs  = (w_state_q == W_IDLE) && wready_q && mem_axi_wvalid;
    assign b_hs  = bvalid_q && mem_axi_bready;

    assign ar_region_in = mem_axi_araddr[ADDR_W-1 -: 4];
    assign ar_ram_idx   = mem_axi_araddr[LSB+RAM_AW-1:LSB];

    // The RAM word is fetched on the AR handshake edge so it is ready in R_FETCH;
    // a write landing on the same edge is not visible (read-first).
    assign ram_re = ar_hs;
    assign ram_we = (w_state_q == W_EXEC) && (aw_region_q == REG_RAM) && !RST;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] lane_mem [RAM_DEPTH];
            logic [7:0] lane_rd_q;
            always_ff @(posedge CLK) begin
                if (ram_we && wstrb_q[gi]) begin
                    lane_mem[aw_idx_q] <= wdata_q[gi*8 +: 8];
                end
                if (ram_re) begin
                    lane_rd_q <= lane_mem[ar_ram_idx];
                end
            end
            assign ram_rd[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

    always_comb begin
        r_state_d   = r_state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        ar_region_d = ar_region_q;
        rom_addr_d  = rom_addr_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d   = 1'b0;
                    ar_region_d = ar_region_in;
                    if (ar_region_in == REG_ROM) begin
                        rom_addr_d = mem_axi_araddr[LSB+ROM_AW-1:LSB];
                    end
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                if (ar_region_q == REG_RAM) begin
                    rdata_d   = ram_rd;
                    rresp_d   = 2'b00;
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                end else if (ar_region_q == REG_ROM) begin
                    if (rom_valid) begin
                        rdata_d   = rom_data;
                        rresp_d   = 2'b00;
                        rvalid_d  = 1'b1;
                        r_state_d = R_RESP;
                    end
                end else begin
                    rdata_d   = UNMAPPED_DATA;
                    rresp_d   = 2'b11;
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (r_hs) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        aw_region_d = aw_region_q;
        aw_idx_d    = aw_idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_region_d = mem_axi_awaddr[ADDR_W-1 -: 4];
                    aw_idx_d    = mem_axi_awaddr[LSB+RAM_AW-1:LSB];
                end
                if (w_hs) begin
                    wdata_d = mem_axi_wdata;
                    wstrb_d = mem_axi_wstrb;
                end
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                // Each ready drops once its own channel is held, independent of the other.
                if (aw_done_d && w_done_d) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_EXEC;
                end else begin
                    awready_d = !aw_done_d;
                    wready_d  = !w_done_d;
                end
            end
            W_EXEC: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                bvalid_d  = 1'b1;
                if (aw_region_q == REG_RAM) begin
                    bresp_d = 2'b00;
                end else if (aw_region_q == REG_ROM) begin
                    bresp_d = 2'b10;
                end else begin
                    bresp_d = 2'b11;
                end
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        err_inc = {1'b0, b_hs && (bresp_q != 2'b00)} + {1'b0, r_hs && (rresp_q != 2'b00)};
        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q   <= R_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
            ar_region_q <= 4'd0;
            rom_addr_q  <= '0;
            w_state_q   <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            aw_region_q <= 4'd0;
            aw_idx_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            err_q       <= 8'd0;
        end else begin
            r_state_q   <= r_state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            ar_region_q <= ar_region_d;
            rom_addr_q  <= rom_addr_d;
            w_state_q   <= w_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            aw_region_q <= aw_region_d;
            aw_idx_q    <= aw_idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            err_q       <= err_d;
        end
    end

    assign mem_axi_arready = arready_q;
    assign mem_axi_rvalid  = rvalid_q;
    assign mem_axi_rdata   = rdata_q;
    assign mem_axi_rresp   = rresp_q;
    assign mem_axi_awready = awready_q;
    assign mem_axi_wready  = wready_q;
    assign mem_axi_bvalid  = bvalid_q;
    assign mem_axi_bresp   = bresp_q;
    assign rom_addr        = rom_addr_q;
    assign err_count       = err_q;
endmodule

// File: tb/tb_axi_lite_mem_ctrl.sv
// Randomized bench for axi_lite_mem_ctrl: directed scenarios plus random traffic,
// checked against an array/arithmetic reference model of the memory map.
module tb_axi_lite_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        rom_valid;
    logic [7:0]  err_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl_ram [1024];
    int          mdl_err = 0;

    logic [1:0]  t_bresp, t_rresp, e_resp;
    logic [31:0] t_rdata, e_data, old_word;

    always #5 clk = ~clk;

    axi_lite_mem_ctrl dut (
        .CLK(clk), .RST(rst),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
        .mem_axi_awprot(3'b000),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
        .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
        .mem_axi_arprot(3'b000),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
        .mem_axi_rresp(rresp),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
        .err_count(err_count)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        return 32'hC3A5_0000 ^ {idx, 6'h15, idx, 6'h2A};
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fatal_timeout(input string tag);
        n_errors++;
        $display("FAIL timeout waiting for %s", tag);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "bench aborted");
    endtask

    // Reference model: region = addr[31:28], word = addr[11:2].
    function automatic logic [1:0] mdl_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
        logic [9:0] idx = addr[11:2];
        if (addr[31:28] == 4'd1) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mdl_ram[idx][b*8 +: 8] = data[b*8 +: 8];
            end
            return 2'b00;
        end
        return (addr[31:28] == 4'd0) ? 2'b10 : 2'b11;
    endfunction

    function automatic void mdl_read(input logic [31:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
        if (addr[31:28] == 4'd0) begin
            data = rom_word(addr[11:2]);
            resp = 2'b00;
        end else if (addr[31:28] == 4'd1) begin
            data = mdl_ram[addr[11:2]];
            resp = 2'b00;
        end else begin
            data = 32'hDEADBEEF;
            resp = 2'b11;
        end
    endfunction

    function automatic void mdl_err_add(input logic [1:0] resp);
        if (resp != 2'b00 && mdl_err < 255) mdl_err++;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs, stable;
        int cyc, lat;
        logic [1:0] resp0;
        aw_done = 0; w_done = 0; stable = 1; cyc = 0; lat = 0;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            awaddr  = addr;
            wvalid  = !w_done && (cyc >= w_dly);
            wdata   = data;
            wstrb   = strb;
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            @(posedge clk); #1;
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            cyc++;
            if (cyc > 100) fatal_timeout("aw/w handshake");
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        while (!bvalid) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 100) fatal_timeout("bvalid");
        end
        check_val("b_latency", lat, 1);
        resp0 = bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            if (!bvalid || bresp !== resp0) stable = 0;
        end
        if (b_dly > 0) check_val("b_hold", stable, 1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check_val("b_drop", bvalid, 0);
        resp = resp0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int rom_dly,
                           input int r_dly, output logic [31:0] data, output logic [1:0] resp);
        bit done, hs, stable;
        int cyc, lat;
        logic [31:0] data0;
        logic [1:0]  resp0;
        done = 0; stable = 1; cyc = 0; lat = 0;
        while (!done) begin
            arvalid = (cyc >= ar_dly);
            araddr  = addr;
            hs      = arvalid && arready;
            @(posedge clk); #1;
            done = hs;
            cyc++;
            if (cyc > 100) fatal_timeout("ar handshake");
        end
        arvalid = 1'b0;
        while (!rvalid) begin
            rom_valid = (lat >= rom_dly);
            @(posedge clk); #1;
            lat++;
            if (lat > 100) fatal_timeout("rvalid");
        end
        rom_valid = 1'b0;
        check_val("r_latency", lat, (addr[31:28] == 4'd0) ? rom_dly + 1 : 1);
        data0 = rdata;
        resp0 = rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            if (!rvalid || rdata !== data0 || rresp !== resp0) stable = 0;
        end
        if (r_dly > 0) check_val("r_hold", stable, 1);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check_val("r_drop", rvalid, 0);
        data = data0;
        resp = resp0;
    endtask

    initial begin
        logic [31:0] addr;
        logic [9:0]  idx;
        logic [3:0]  region;
        int          r, sel;
        bit          quiet;

        rst = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; rom_valid = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_arready", arready, 0);
        check_val("rst_awready", awready, 0);
        check_val("rst_wready", wready, 0);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_bvalid", bvalid, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_rom_addr", rom_addr, 0);
        check_val("rst_err", err_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("rdy_after_rst", {arready, awready, wready}, 3'b111);

        // Full-word write then readback, then partial-strobe merge
        do_write(32'h1000_0004, 32'hA5A5A5A5, 4'hF, 0, 0, 0, t_bresp);
        e_resp = mdl_write(32'h1000_0004, 32'hA5A5A5A5, 4'hF);
        check_val("wr_full_bresp", t_bresp, e_resp);
        do_read(32'h1000_0004, 0, 0, 0, t_rdata, t_rresp);
        check_val("rd_full_data", t_rdata, 32'hA5A5A5A5);
        check_val("rd_full_rresp", t_rresp, 2'b00);
        do_write(32'h1000_0004, 32'h11223344, 4'h5, 0, 0, 0, t_bresp);
        e_resp = mdl_write(32'h1000_0004, 32'h11223344, 4'h5);
        do_read(32'h1000_0004, 1, 0, 2, t_rdata, t_rresp);
        check_val("rd_strb_merge", t_rdata, 32'hA522A544);

        // W leads AW by 3 cycles, response held for 4 cycles
        do_write(32'h1000_0008, 32'h0BADF00D, 4'hF, 3, 0, 4, t_bresp);
        e_resp = mdl_write(32'h1000_0008, 32'h0BADF00D, 4'hF);
        check_val("wr_wfirst_bresp", t_bresp, e_resp);
        do_read(32'h1000_0008, 0, 0, 0, t_rdata, t_rresp);
        check_val("rd_wfirst_data", t_rdata, 32'h0BADF00D);

        // Reset while the write is in its execute cycle: no RAM update, no response
        check_val("aw_ready_idle", {awready, wready}, 2'b11);
        awvalid = 1'b1; wvalid = 1'b1;
        awaddr = 32'h1000_0004; wdata = 32'hFFFF0000; wstrb = 4'hF;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_err = 0;
        quiet = 1;
        for (int i = 0; i < 3; i++) begin
            if (bvalid) quiet = 0;
            @(posedge clk); #1;
        end
        check_val("rst_no_bvalid", quiet, 1);
        do_read(32'h1000_0004, 0, 0, 0, t_rdata, t_rresp);
        check_val("rst_no_write", t_rdata, 32'hA522A544);

        // ROM write rejected, unmapped read errors
        do_write(32'h0000_0000, 32'h12345678, 4'hF, 0, 0, 0, t_bresp);
        check_val("rom_wr_bresp", t_bresp, 2'b10);
        do_read(32'h2000_0000, 0, 0, 0, t_rdata, t_rresp);
        check_val("unm_rdata", t_rdata, 32'hDEADBEEF);
        check_val("unm_rresp", t_rresp, 2'b11);
        check_val("err_two", err_count, 2);
        mdl_err = 2;

        // ROM read with rom_valid held low for 5 fetch cycles
        do_read(32'h0000_0010, 0, 5, 1, t_rdata, t_rresp);
        check_val("rom_rdata", t_rdata, rom_word(10'd4));
        check_val("rom_rresp", t_rresp, 2'b00);

        // Initialise the RAM word pool: indices 0..7 and 1016..1023
        for (int p = 0; p < 16; p++) begin
            idx = (p < 8) ? 10'(p) : 10'(1016 + p - 8);
            addr = {4'h1, 16'h0000, idx, 2'b00};
            wdata = $urandom;
            e_data = wdata;
            do_write(addr, e_data, 4'hF, 0, 0, 0, t_bresp);
            e_resp = mdl_write(addr, e_data, 4'hF);
        end

        // Random traffic with aliased upper/low address bits
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 15);
            idx = (r < 8) ? 10'(r) : 10'(1016 + r - 8);
            sel = $urandom_range(0, 7);
            region = (sel == 0) ? 4'd0 : (sel <= 5) ? 4'd1 : 4'($urandom_range(2, 15));
            addr = {region, 16'($urandom), idx, 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                e_data = $urandom;
                wstrb = 4'($urandom_range(0, 15));
                e_resp = mdl_write(addr, e_data, wstrb);
                do_write(addr, e_data, wstrb, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), t_bresp);
                check_val("rnd_bresp", t_bresp, e_resp);
            end else begin
                mdl_read(addr, e_data, e_resp);
                do_read(addr, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                        t_rdata, t_rresp);
                check_val("rnd_rdata", t_rdata, e_data);
                check_val("rnd_rresp", t_rresp, e_resp);
            end
            mdl_err_add(e_resp);
            check_val("rnd_err", err_count, mdl_err);
        end

        // Concurrent read and write of the same RAM word returns the old data
        old_word = mdl_ram[0];
        fork
            do_write(32'h1000_0000, 32'h600DCAFE, 4'hF, 0, 0, 0, t_bresp);
            do_read(32'h1000_0000, 0, 0, 0, t_rdata, t_rresp);
        join
        e_resp = mdl_write(32'h1000_0000, 32'h600DCAFE, 4'hF);
        check_val("conc_old_data", t_rdata, old_word);
        do_read(32'h1000_0000, 0, 0, 0, t_rdata, t_rresp);
        check_val("conc_new_data", t_rdata, 32'h600DCAFE);

        // B and R errors in the same cycle count twice
        fork
            do_write(32'h0000_0040, 32'h0, 4'hF, 0, 0, 0, t_bresp);
            do_read(32'h5000_0000, 0, 0, 0, t_rdata, t_rresp);
        join
        mdl_err_add(2'b10);
        mdl_err_add(2'b11);
        check_val("err_double", err_count, mdl_err);

        // Drive the counter to 254, then a double increment must saturate at 255
        while (mdl_err < 254) begin
            do_read(32'h3000_0000, 0, 0, 0, t_rdata, t_rresp);
            mdl_err_add(2'b11);
        end
        check_val("err_254", err_count, 254);
        fork
            do_write(32'h0000_0040, 32'h0, 4'hF, 0, 0, 0, t_bresp);
            do_read(32'hF000_0000, 0, 0, 0, t_rdata, t_rresp);
        join
        check_val("err_sat_double", err_count, 8'hFF);
        do_read(32'h3000_0000, 0, 0, 0, t_rdata, t_rresp);
        check_val("err_sat_hold", err_count, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_ctrl.md
AXI_LITE_MEM_CTRL -- requirements
Module: axi_lite_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port CLK, reset port RST.
REQ-002 Parameter DATA_W SHALL default to 32 and set the AXI data width; legal values are 32 and 64; STRB_W = DATA_W/8; LSB = log2(STRB_W).
REQ-003 Parameter ADDR_W SHALL default to 32 and set the AXI address width; the region field is addr[ADDR_W-1:ADDR_W-4].
REQ-004 Parameter RAM_AW SHALL default to 10 and set the internal RAM word-address width (depth 2^RAM_AW words).
REQ-005 Parameter ROM_AW SHALL default to 10 and set the external ROM word-address width.
REQ-006 Ports SHALL be:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
mem_axi_awvalid/awready  in/out  1  write-address handshake
mem_axi_awaddr  in  ADDR_W  write address
mem_axi_awprot  in  3  ignored
mem_axi_wvalid/wready  in/out  1  write-data handshake
mem_axi_wdata  in  DATA_W  write data
mem_axi_wstrb  in  STRB_W  byte enables
mem_axi_bvalid/bready  out/in  1  write-response handshake
mem_axi_bresp  out  2  write response
mem_axi_arvalid/arready  in/out  1  read-address handshake
mem_axi_araddr  in  ADDR_W  read address
mem_axi_arprot  in  3  ignored
mem_axi_rvalid/rready  out/in  1  read-data handshake
mem_axi_rdata  out  DATA_W  read data
mem_axi_rresp  out  2  read response
rom_addr  out  ROM_AW  external ROM word address
rom_data  in  DATA_W  external ROM data
rom_valid  in  1  rom_data valid for current rom_addr
err_count  out  8  saturating count of error responses

Function
REQ-007 Region decode: 0 = external ROM (read-only), 1 = internal RAM, 2..15 = unmapped.
REQ-008 Word index = addr[LSB+RAM_AW-1:LSB] (RAM) or addr[LSB+ROM_AW-1:LSB] (ROM); addr[LSB-1:0] and unused bits within a region are ignored, so addresses alias/wrap within the region.
REQ-009 Every handshake SHALL complete only on the cycle valid and ready are both high; outputs valid SHALL hold, with stable data/resp, until the matching ready.
REQ-010 Read FSM states R_IDLE, R_FETCH, R_RESP: R_IDLE drives arready=1; on AR handshake latch araddr, drive rom_addr if ROM, go R_FETCH.
REQ-011 R_FETCH: RAM -> capture RAM word after exactly one cycle, rresp=2'b00; ROM -> wait for rom_valid=1, capture rom_data, rresp=2'b00; unmapped -> rdata=32'hDEADBEEF zero-extended to DATA_W, rresp=2'b11; then R_RESP.
REQ-012 R_RESP: rvalid=1 until rready; on R handshake return to R_IDLE. RAM read: AR handshake cycle N -> rvalid first high in cycle N+2.
REQ-013 Write FSM states W_IDLE, W_EXEC, W_RESP: in W_IDLE awready and wready are independently 1 until their own channel has been captured; AW and W may arrive in either order or in the same cycle.
REQ-014 When both are captured, go W_EXEC (one cycle): RAM -> write only bytes with wstrb=1, bresp=2'b00; ROM -> no write, bresp=2'b10; unmapped -> no write, bresp=2'b11; then W_RESP.
REQ-015 W_RESP: bvalid=1 until bready; on B handshake return to W_IDLE. Minimum: AW+W same cycle N -> bvalid at N+2.
REQ-016 wstrb=0 to RAM SHALL complete with bresp=2'b00 and leave RAM unchanged.
REQ-017 Read and write FSMs SHALL operate concurrently; RAM read and write of the same word in the same cycle SHALL return the old data (read-first).
REQ-018 err_count SHALL increment by 1 on each B or R handshake carrying a non-zero resp, saturating at 8'hFF; both in one cycle increment by 2, saturating.

Reset
REQ-019 While RST=1: FSMs -> idle, arready/awready/wready/rvalid/bvalid=0, rdata=0, rresp=0, bresp=0, rom_addr=0, err_count=0; readies assert the first cycle after RST falls.
REQ-020 Reset mid-transaction SHALL abandon it without RAM write or response; RAM contents are not cleared by reset.

Verification
REQ-021 Write 0x1000_0004 data 0xA5A5A5A5 strb 0xF, then read it -> bresp=00, rdata=0xA5A5A5A5, rresp=00, rvalid at AR+2.
REQ-022 Write 0x1000_0004 data 0x11223344 strb 0x5 over 0xA5A5A5A5 -> readback 0xA522A544.
REQ-023 W presented 3 cycles before AW, bready held low 4 cycles -> one write, bvalid stable until bready.
REQ-024 Write 0x0000_0000 then read 0x2000_0000 -> bresp=10, rdata=0xDEADBEEF, rresp=11, err_count=2.
REQ-025 ROM read with rom_valid low 5 cycles -> rvalid waits, rdata=rom_data at rom_valid; RST during W_EXEC-pending -> no RAM change, no bvalid.
